// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment display reader.
// Glyphs are SEG[7:1] (a..g), active-low.
package seg7_pkg;

  typedef logic [6:0] glyph_t;

  localparam glyph_t GLYPH_0 = 7'b0000001;
  localparam glyph_t GLYPH_1 = 7'b1001111;
  localparam glyph_t GLYPH_2 = 7'b0010010;
  localparam glyph_t GLYPH_3 = 7'b0000110;
  localparam glyph_t GLYPH_4 = 7'b1001100;
  localparam glyph_t GLYPH_5 = 7'b0100100;
  localparam glyph_t GLYPH_6 = 7'b0100000;
  localparam glyph_t GLYPH_7 = 7'b0001111;
  localparam glyph_t GLYPH_8 = 7'b0000000;
  localparam glyph_t GLYPH_9 = 7'b0000100;
  localparam glyph_t GLYPH_A = 7'b0001000;
  localparam glyph_t GLYPH_B = 7'b1100000;
  localparam glyph_t GLYPH_C = 7'b1110010;
  localparam glyph_t GLYPH_D = 7'b1000010;
  localparam glyph_t GLYPH_E = 7'b0110000;
  localparam glyph_t GLYPH_F = 7'b0111000;
  localparam glyph_t BLANK   = 7'b1111111;

  typedef struct packed {
    logic [3:0] nibble;
    logic       recognized;
    logic       blank;
  } decode_t;

  // True when exactly one active-low digit select is asserted.
  function automatic logic single_select(input logic [3:0] dig);
    logic sel;
    case (dig)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: sel = 1'b1;
      default:                            sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: active-low segment pattern to hex nibble,
// with recognized/blank flags.
module seg7_decode
  import seg7_pkg::*;
(
  input  glyph_t  glyph,
  output decode_t result
);

  always_comb begin
    result.nibble     = 4'h0;
    result.recognized = 1'b1;
    result.blank      = 1'b0;
    unique case (glyph)
      GLYPH_0: result.nibble = 4'h0;
      GLYPH_1: result.nibble = 4'h1;
      GLYPH_2: result.nibble = 4'h2;
      GLYPH_3: result.nibble = 4'h3;
      GLYPH_4: result.nibble = 4'h4;
      GLYPH_5: result.nibble = 4'h5;
      GLYPH_6: result.nibble = 4'h6;
      GLYPH_7: result.nibble = 4'h7;
      GLYPH_8: result.nibble = 4'h8;
      GLYPH_9: result.nibble = 4'h9;
      GLYPH_A: result.nibble = 4'hA;
      GLYPH_B: result.nibble = 4'hB;
      GLYPH_C: result.nibble = 4'hC;
      GLYPH_D: result.nibble = 4'hD;
      GLYPH_E: result.nibble = 4'hE;
      GLYPH_F: result.nibble = 4'hF;
      BLANK: begin
        result.recognized = 1'b0;
        result.blank      = 1'b1;
      end
      default: result.recognized = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed 4-digit 7-segment display bus back into hex values.
// Patterns are synchronized, debounced for STABLE_CYCLES samples, then decoded.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  SEG,
  input  logic [3:0]  DIG,
  input  logic        CLR_ERR,
  output logic [15:0] VALUE,
  output logic [3:0]  DP,
  output logic [3:0]  DIG_OK,
  output logic        ERR,
  output logic        UPDATE
);

  localparam logic [4:0] CntAccept = 5'(STABLE_CYCLES);
  localparam logic [4:0] CntSat    = 5'(STABLE_CYCLES + 1);

  logic [7:0]  seg_meta_q, seg_sync_q;
  logic [3:0]  dig_meta_q, dig_sync_q;
  logic [11:0] pat;
  logic [11:0] pat_prev_q;
  logic [4:0]  cnt_q, cnt_d;

  logic [15:0] value_q, value_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  ok_q, ok_d;
  logic        err_q, err_d;
  logic        upd_q, upd_d;

  logic [3:0]  acc_dig;
  logic [7:0]  acc_seg;
  logic        accept;
  decode_t     dec;

  assign pat     = {dig_sync_q, seg_sync_q};
  assign acc_dig = pat_prev_q[11:8];
  assign acc_seg = pat_prev_q[7:0];

  // The counter saturates one past the threshold, so the threshold value
  // is seen for exactly one cycle per stable period.
  assign accept = (cnt_q == CntAccept) && single_select(acc_dig);

  seg7_decode u_decode (
    .glyph  (acc_seg[7:1]),
    .result (dec)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (pat != pat_prev_q) begin
      cnt_d = 5'd1;
    end else if (cnt_q != CntSat) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    ok_d    = ok_q;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (!acc_dig[i]) begin
          if (dec.recognized) begin
            value_d[4*i +: 4] = dec.nibble;
          end
          ok_d[i] = dec.recognized;
          dp_d[i] = ~acc_seg[0];
        end
      end
    end
    // A new error wins over a simultaneous clear.
    err_d = (err_q & ~CLR_ERR) | (accept & ~dec.recognized & ~dec.blank);
    upd_d = (value_d != value_q) || (dp_d != dp_q) || (ok_d != ok_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      dig_meta_q <= '1;
      dig_sync_q <= '1;
      pat_prev_q <= '1;
      cnt_q      <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      ok_q       <= '0;
      err_q      <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      seg_meta_q <= SEG;
      seg_sync_q <= seg_meta_q;
      dig_meta_q <= DIG;
      dig_sync_q <= dig_meta_q;
      pat_prev_q <= pat;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      upd_q      <= upd_d;
    end
  end

  assign VALUE  = value_q;
  assign DP     = dp_q;
  assign DIG_OK = ok_q;
  assign ERR    = err_q;
  assign UPDATE = upd_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios plus random scan traffic, checked
// every cycle against a sample-history model of the display reader.
module tb_seg7_reader;

  localparam int S    = 4;
  localparam int MAXE = 8192;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CLR_ERR = 1'b0;
  logic [7:0]  SEG = 8'hFF;
  logic [3:0]  DIG = 4'hF;
  logic [15:0] VALUE;
  logic [3:0]  DP, DIG_OK;
  logic        ERR, UPDATE;

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SEG     (SEG),
    .DIG     (DIG),
    .CLR_ERR (CLR_ERR),
    .VALUE   (VALUE),
    .DP      (DP),
    .DIG_OK  (DIG_OK),
    .ERR     (ERR),
    .UPDATE  (UPDATE)
  );

  always #5 CLK = ~CLK;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Raw input and reset per edge, the synchronized stream seen at each edge,
  // and how long that stream value has been unchanged.
  logic [11:0] in_hist  [MAXE];
  bit          rst_hist [MAXE];
  logic [11:0] y_hist   [MAXE];
  int          run_hist [MAXE];

  logic [15:0] m_value = '0;
  logic [3:0]  m_dp = '0, m_ok = '0;
  logic        m_err = 1'b0, m_upd = 1'b0;

  int n_tests = 0, n_fail = 0;
  int ed = 0, pulses = 0, last_upd = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ed, got, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] d, input logic [7:0] s, input logic c,
                            input logic r);
    logic [11:0] y, pat;
    logic [3:0]  sel_n, ndp, nok;
    logic [15:0] nv;
    logic [6:0]  g;
    logic        acc;
    int          digit, idx;
    in_hist[ed]  = {d, s};
    rst_hist[ed] = r;
    // A pattern needs two clean edges to cross the synchronizer.
    if (ed >= 2 && !rst_hist[ed-1] && !rst_hist[ed-2]) y = in_hist[ed-2];
    else y = '1;
    y_hist[ed] = y;
    if (r) run_hist[ed] = 0;
    else if (ed == 0 || rst_hist[ed-1]) run_hist[ed] = 1;
    else if (y == y_hist[ed-1]) run_hist[ed] = run_hist[ed-1] + 1;
    else run_hist[ed] = 1;
    if (r) begin
      m_value = '0; m_dp = '0; m_ok = '0; m_err = 1'b0; m_upd = 1'b0;
      return;
    end
    acc = (ed >= 1) && (run_hist[ed-1] == S);
    pat = (ed >= 1) ? y_hist[ed-1] : '1;
    nv = m_value; ndp = m_dp; nok = m_ok;
    m_err = m_err && !c;
    sel_n = ~pat[11:8];
    if (acc && $countones(sel_n) == 1) begin
      digit = 0;
      for (int i = 0; i < 4; i++) if (sel_n[i]) digit = i;
      g = pat[7:1];
      idx = -1;
      for (int j = 0; j < 16; j++) if (glyph_tab[j] == g) idx = j;
      if (idx >= 0) begin
        nv[digit*4 +: 4] = idx[3:0];
        nok[digit] = 1'b1;
      end else begin
        nok[digit] = 1'b0;
        if (g != 7'h7F) m_err = 1'b1;
      end
      ndp[digit] = ~pat[0];
    end
    m_upd = (nv != m_value) || (ndp != m_dp) || (nok != m_ok);
    m_value = nv; m_dp = ndp; m_ok = nok;
  endtask

  task automatic step(input logic [3:0] d, input logic [7:0] s, input logic c, input logic r);
    @(negedge CLK);
    DIG = d; SEG = s; CLR_ERR = c; RESET = r;
    @(posedge CLK);
    model_edge(d, s, c, r);
    #1;
    check_eq("VALUE", VALUE, m_value);
    check_eq("DP", DP, m_dp);
    check_eq("DIG_OK", DIG_OK, m_ok);
    check_eq("ERR", ERR, m_err);
    check_eq("UPDATE", UPDATE, m_upd);
    if (UPDATE === 1'b1) begin
      pulses++;
      last_upd = ed;
    end
    ed++;
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(d, s, 1'b0, 1'b0);
  endtask

  task automatic scan();
    hold(4'b1110, {glyph_tab[1], 1'b1}, 8);
    hold(4'b1101, {glyph_tab[10], 1'b1}, 8);
    hold(4'b1011, {glyph_tab[2], 1'b0}, 8);
    hold(4'b0111, {glyph_tab[15], 1'b1}, 8);
  endtask

  initial begin
    int k;
    logic [3:0] one, d;
    logic [7:0] s;
    one = 4'b0001;

    for (int i = 0; i < 3; i++) step(4'hF, 8'hFF, 1'b0, 1'b1);
    check_eq("rst_value", VALUE, 16'h0);
    check_eq("rst_err", ERR, 1'b0);

    // Single digit, full hold: one update six edges after first sample.
    k = ed; pulses = 0;
    hold(4'b1110, 8'b00001101, 10);
    check_eq("single_pulses", pulses, 1);
    check_eq("single_latency", last_upd - k, 6);
    check_eq("single_value", VALUE, 16'h0003);
    check_eq("single_ok", DIG_OK, 4'b0001);
    check_eq("single_dp", DP, 4'b0000);

    // Full scan, then identical rescan.
    pulses = 0;
    scan();
    check_eq("scan_pulses", pulses, 4);
    check_eq("scan_value", VALUE, 16'hF2A1);
    check_eq("scan_dp", DP, 4'b0100);
    check_eq("scan_ok", DIG_OK, 4'b1111);
    pulses = 0;
    scan();
    check_eq("rescan_pulses", pulses, 0);

    // Short hold and glitch inside a hold.
    step(4'hF, 8'hFF, 1'b0, 1'b1);
    step(4'hF, 8'hFF, 1'b0, 1'b1);
    pulses = 0;
    hold(4'b1110, {glyph_tab[3], 1'b1}, 3);
    hold(4'b1110, 8'hFF, 8);
    check_eq("short_pulses", pulses, 0);
    check_eq("short_value", VALUE, 16'h0);
    hold(4'b1110, {glyph_tab[3], 1'b1}, 3);
    hold(4'b1110, 8'hFF, 1);
    k = ed;
    hold(4'b1110, {glyph_tab[3], 1'b1}, 3);
    check_eq("glitch_pulses", pulses, 0);
    hold(4'b1110, {glyph_tab[3], 1'b1}, 5);
    check_eq("glitch_restart", last_upd - k, 6);
    check_eq("glitch_value", VALUE, 16'h0003);

    // Unrecognized glyph, clear, and clear coinciding with a new error.
    hold(4'b1011, 8'b01010101, 8);
    check_eq("bad_err", ERR, 1'b1);
    check_eq("bad_ok2", DIG_OK[2], 1'b0);
    check_eq("bad_value", VALUE, 16'h0003);
    step(4'b1011, 8'b01010101, 1'b1, 1'b0);
    check_eq("clr_err", ERR, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(4'b1011, 8'b01010111, (i == 6), 1'b0);
      if (i == 6) check_eq("clr_coincide", ERR, 1'b1);
    end
    step(4'b1011, 8'b01010111, 1'b1, 1'b0);

    // Illegal digit selects are ignored.
    pulses = 0;
    hold(4'b1100, {glyph_tab[8], 1'b1}, 8);
    hold(4'b1111, {glyph_tab[8], 1'b1}, 8);
    check_eq("badsel_pulses", pulses, 0);
    check_eq("badsel_err", ERR, 1'b0);
    check_eq("badsel_value", VALUE, 16'h0003);

    // Reset in the middle of a hold restarts the stable period.
    k = ed;
    for (int i = 0; i < 14; i++) begin
      step(4'b1101, {glyph_tab[5], 1'b1}, 1'b0, (i == 3));
      if (i == 3) begin
        check_eq("midrst_value", VALUE, 16'h0);
        check_eq("midrst_ok", DIG_OK, 4'h0);
      end
    end
    check_eq("midrst_latency", last_upd - k, 10);
    check_eq("midrst_final", VALUE, 16'h0050);

    // Random scan traffic.
    for (int n = 0; n < 400 && ed < MAXE - 64; n++) begin
      if ($urandom_range(0, 9) < 8) d = ~(one << $urandom_range(0, 3));
      else d = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: s = {glyph_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
        7:                   s = {7'h7F, 1'($urandom_range(0, 1))};
        default:             s = 8'($urandom_range(0, 255));
      endcase
      for (int i = 0, len = $urandom_range(1, 9); i < len; i++) begin
        step(d, s, ($urandom_range(0, 24) == 0), ($urandom_range(0, 199) == 0));
      end
    end
    hold(4'hF, 8'hFF, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive synchronized samples a {DIG,SEG} pattern must hold before acceptance (legal range 2..15).
REQ-002 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port SEG  input  8  active-low segment bus: bit7=a … bit1=g, bit0=dp.
REQ-005 SHALL have port DIG  input  4  active-low digit select; DIG[i]=0 selects digit i.
REQ-006 SHALL have port CLR_ERR  input  1  clears ERR.
REQ-007 SHALL have port VALUE  output  16  decoded digits; VALUE[4i+3:4i] = digit i.
REQ-008 SHALL have port DP  output  4  captured decimal point per digit, 1 = lit.
REQ-009 SHALL have port DIG_OK  output  4  1 = digit i holds a recognized hex glyph.
REQ-010 SHALL have port ERR  output  1  sticky: unrecognized glyph accepted.
REQ-011 SHALL have port UPDATE  output  1  one-cycle pulse when VALUE, DP or DIG_OK changed.

Function
REQ-012 SHALL pass SEG and DIG through a 2-flop synchronizer before any use.
REQ-013 SHALL count consecutive cycles the synchronized {DIG,SEG} is unchanged; any change restarts the count; count saturates.
REQ-014 SHALL accept a pattern exactly once per stable period, when the count first reaches STABLE_CYCLES.
REQ-015 Timing: inputs first sampled at edge k and held through edge k+STABLE_CYCLES+1 SHALL update outputs and pulse UPDATE at edge k+STABLE_CYCLES+2.
REQ-016 Patterns held fewer samples SHALL be discarded with no output change.
REQ-017 Acceptance SHALL be ignored unless synchronized DIG has exactly one zero bit (1111, 1100 etc. ignored, no error).
REQ-018 Decode SHALL compare SEG[7:1] against the 16 active-low glyphs 0..F (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=1110010, d=1000010, E=0110000, F=0111000).
REQ-019 Recognized glyph on digit i SHALL write nibble i, set DIG_OK[i]=1, set DP[i]=~SEG[0].
REQ-020 Blank glyph (SEG[7:1]=1111111) SHALL clear DIG_OK[i], keep nibble i, set DP[i]=~SEG[0], not set ERR.
REQ-021 Any other glyph SHALL clear DIG_OK[i], keep nibble i, set DP[i]=~SEG[0], set ERR.
REQ-022 UPDATE SHALL pulse only if the accepted write changed nibble i, DP[i] or DIG_OK[i]; rewriting identical data SHALL not pulse.
REQ-023 ERR SHALL hold until CLR_ERR=1; simultaneous CLR_ERR and new error SHALL leave ERR=1.
REQ-024 Only one digit SHALL be written per acceptance; other digits unchanged.

Reset
REQ-025 RESET SHALL force VALUE=0, DP=0, DIG_OK=0, ERR=0, UPDATE=0, stability count=0, synchronizers=all-ones (idle).
REQ-026 RESET asserted mid-stable-period SHALL abort acceptance; the pattern SHALL need a full new stable period after release.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16 glyph constants, the BLANK constant and a 7-bit glyph typedef.
REQ-028 Combinational sub-module seg7_decode SHALL map glyph -> {nibble, recognized, blank}; instantiated once.

Verification
REQ-029 STABLE_CYCLES=4, SEG=00001101, DIG=1110 held 10 cycles -> VALUE=0x0003, DIG_OK=0001, DP=0000, one UPDATE at edge k+6.
REQ-030 Scan DIG=1110/1101/1011/0111 with glyphs 1,A,2,F (dp on for digit 2), 8 cycles each -> VALUE=0xF2A1, DP=0100, DIG_OK=1111, 4 UPDATE pulses; repeated scan -> no further pulses.
REQ-031 Glyph 3 on digit 0 held 3 cycles then SEG=11111111 -> no update; 1-cycle glitch inside a stable hold restarts count.
REQ-032 SEG=01010101, DIG=1011 held 8 cycles -> ERR=1, DIG_OK[2]=0, nibble 2 unchanged; CLR_ERR pulse -> ERR=0; CLR_ERR coincident with new error -> ERR=1.
REQ-033 DIG=1100 or 1111 with valid glyph held 8 cycles -> no output change, ERR=0.
REQ-034 RESET pulse at edge k+3 of a stable hold -> all outputs 0; hold continued -> update at release edge+STABLE_CYCLES+2.
